// File: rtl/tx_frame_arbiter_pkg.sv
// tx_frame_arbiter_pkg: default parameters and shared types for the FT245 tx frame arbiter.
package tx_frame_arbiter_pkg;

    localparam int         TX_DATA_WIDTH_D = 8;
    localparam logic [7:0] HDR_CH1_D       = 8'h01;
    localparam logic [7:0] HDR_CH2_D       = 8'h02;
    localparam int         MAX_FRAME_D     = 4096;

    typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;
    typedef enum logic {CH1, CH2} ch_t;

endpackage

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin framing of the channel-1/channel-2 tx streams onto the FT245 tx port.
module tx_frame_arbiter
    import tx_frame_arbiter_pkg::*;
#(
    parameter int                     TX_DATA_WIDTH = TX_DATA_WIDTH_D,
    parameter logic [TX_DATA_WIDTH-1:0] HDR_CH1     = TX_DATA_WIDTH'(HDR_CH1_D),
    parameter logic [TX_DATA_WIDTH-1:0] HDR_CH2     = TX_DATA_WIDTH'(HDR_CH2_D),
    parameter int                     MAX_FRAME     = MAX_FRAME_D
) (
    input  logic                     clk_i,
    input  logic                     rst,
    input  logic                     rqst_ch1_data,
    input  logic                     rqst_ch2_data,
    input  logic                     abort,
    input  logic [TX_DATA_WIDTH-1:0] ch1_data,
    input  logic                     ch1_rdy,
    input  logic                     ch1_eof,
    output logic                     ch1_ack,
    input  logic [TX_DATA_WIDTH-1:0] ch2_data,
    input  logic                     ch2_rdy,
    input  logic                     ch2_eof,
    output logic                     ch2_ack,
    output logic [TX_DATA_WIDTH-1:0] tx_data,
    output logic                     tx_rdy,
    input  logic                     tx_ack,
    output logic                     busy,
    output logic                     frame_done,
    output logic                     truncated
);

    localparam int CW = $clog2(MAX_FRAME + 1);

    state_t                   state, state_n;
    ch_t                      grant, grant_n;
    logic                     pend1, pend2;
    logic [CW-1:0]            word_cnt;
    logic [TX_DATA_WIDTH-1:0] sel_data;
    logic                     sel_rdy, sel_eof, xfer, at_max, start, ends;

    // grant doubles as last_grant: it keeps the served channel until the next grant
    assign sel_data = (grant == CH1) ? ch1_data : ch2_data;
    assign sel_rdy  = (grant == CH1) ? ch1_rdy  : ch2_rdy;
    assign sel_eof  = (grant == CH1) ? ch1_eof  : ch2_eof;
    assign xfer     = (state == DATA) && sel_rdy && tx_ack;
    assign at_max   = word_cnt == CW'(MAX_FRAME - 1);
    assign ends     = xfer && (sel_eof || at_max);
    assign start    = (state == IDLE) && (pend1 || pend2) && !abort;
    assign grant_n  = (pend1 && pend2) ? ((grant == CH1) ? CH2 : CH1) : (pend1 ? CH1 : CH2);

    assign busy    = state != IDLE;
    assign tx_rdy  = (state == HEADER) || ((state == DATA) && sel_rdy);
    assign tx_data = (state == HEADER) ? ((grant == CH1) ? HDR_CH1 : HDR_CH2) :
                     (state == DATA)   ? sel_data : '0;
    assign ch1_ack = (state == DATA) && (grant == CH1) && ch1_rdy && tx_ack;
    assign ch2_ack = (state == DATA) && (grant == CH2) && ch2_rdy && tx_ack;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start  ? HEADER : IDLE;
            HEADER:  state_n = tx_ack ? DATA   : HEADER;
            DATA:    state_n = ends   ? IDLE   : DATA;
            default: state_n = IDLE;
        endcase
        if (abort)
            state_n = IDLE;
    end

    always_ff @(posedge clk_i or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            grant      <= CH2;
            pend1      <= 1'b0;
            pend2      <= 1'b0;
            word_cnt   <= '0;
            frame_done <= 1'b0;
            truncated  <= 1'b0;
        end else begin
            state      <= state_n;
            grant      <= start ? grant_n : grant;
            pend1      <= !abort && (rqst_ch1_data || (pend1 && !(start && grant_n == CH1)));
            pend2      <= !abort && (rqst_ch2_data || (pend2 && !(start && grant_n == CH2)));
            word_cnt   <= (state == HEADER) ? '0 : xfer ? word_cnt + 1'b1 : word_cnt;
            frame_done <= ends || (abort && state != IDLE);
            truncated  <= ends && !sel_eof;
        end
    end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// tb_tx_frame_arbiter: directed checks of framing, round robin, back-pressure, truncation, abort and async reset.
module tb_tx_frame_arbiter;
  localparam int MF = 5;
  logic clk_i = 1'b0, rst = 1'b0;
  logic rqst_ch1_data = 1'b0, rqst_ch2_data = 1'b0, abort = 1'b0;
  logic [7:0] ch1_data, ch2_data, tx_data;
  logic ch1_rdy, ch1_eof, ch1_ack, ch2_rdy, ch2_eof, ch2_ack;
  logic tx_rdy, tx_ack = 1'b0, busy, frame_done, truncated;
  int total = 0, bad = 0;
  logic [7:0] s1[$], s2[$], txq[$], expq[$];
  int i1 = 0, i2 = 0, eof1 = -1, eof2 = -1;
  int fd_cnt, tr_cnt, tr_only, ack2_cnt, busy_cnt;
  bit gate2 = 1'b1, rnd2 = 1'b0, toggle = 1'b0, stab = 1'b0, hold_p = 1'b0, hold2 = 1'b0;
  logic [7:0] hold_d;
  tx_frame_arbiter #(.MAX_FRAME(MF)) dut (
    .clk_i(clk_i), .rst(rst),
    .rqst_ch1_data(rqst_ch1_data), .rqst_ch2_data(rqst_ch2_data), .abort(abort),
    .ch1_data(ch1_data), .ch1_rdy(ch1_rdy), .ch1_eof(ch1_eof), .ch1_ack(ch1_ack),
    .ch2_data(ch2_data), .ch2_rdy(ch2_rdy), .ch2_eof(ch2_eof), .ch2_ack(ch2_ack),
    .tx_data(tx_data), .tx_rdy(tx_rdy), .tx_ack(tx_ack),
    .busy(busy), .frame_done(frame_done), .truncated(truncated)
  );
  always #5 clk_i = ~clk_i;
  task automatic ok(input string t, input bit c);
    total++;
    if (!c) begin
      bad++;
      $error("FAIL %s", t);
    end
  endtask
  function automatic string q2s(input logic [7:0] q[$]);
    string s = "";
    foreach (q[k]) s = {s, $sformatf("%02h ", q[k])};
    return s;
  endfunction
  task automatic drive();
    if (rnd2 && !hold2) gate2 = 1'($urandom_range(0, 1));
    ch1_rdy = i1 < s1.size();
    ch1_data = ch1_rdy ? s1[i1] : 8'h00;
    ch1_eof = ch1_rdy && (i1 == eof1);
    ch2_rdy = (i2 < s2.size()) && gate2;
    ch2_data = ch2_rdy ? s2[i2] : 8'h00;
    ch2_eof = ch2_rdy && (i2 == eof2);
    if (toggle) tx_ack = ~tx_ack;
  endtask
  task automatic cyc();
    drive();
    #1;
    if (tx_rdy && tx_ack) txq.push_back(tx_data);
    if (ch1_rdy && ch1_ack) i1++;
    if (ch2_rdy && ch2_ack) i2++;
    if (stab && hold_p) ok("hold stable", {tx_rdy, tx_data} === {1'b1, hold_d});
    hold_p = tx_rdy && !tx_ack;
    hold_d = tx_data;
    hold2 = ch2_rdy && !ch2_ack;
    fd_cnt += int'(frame_done);
    tr_cnt += int'(truncated);
    tr_only += int'(truncated && !frame_done);
    ack2_cnt += int'(ch2_ack);
    busy_cnt += int'(busy);
    @(posedge clk_i);
    #1;
  endtask
  task automatic settle(input int max);
    int idle = 0;
    for (int k = 0; k < max && idle < 3; k++) begin
      idle = busy ? 0 : idle + 1;
      cyc();
    end
    ok("settle timeout", idle >= 3);
  endtask
  task automatic clr();
    txq.delete();
    fd_cnt = 0; tr_cnt = 0; tr_only = 0; ack2_cnt = 0; busy_cnt = 0;
    i1 = 0; i2 = 0;
  endtask
  initial begin
    clr();
    drive();
    #3;
    ok("rst tx_rdy", tx_rdy === 1'b0);
    ok("rst tx_data", tx_data === 8'h00);
    ok("rst ch1_ack", ch1_ack === 1'b0);
    ok("rst ch2_ack", ch2_ack === 1'b0);
    ok("rst busy", busy === 1'b0);
    ok("rst frame_done", frame_done === 1'b0);
    ok("rst truncated", truncated === 1'b0);
    @(negedge clk_i) rst = 1'b1;
    @(posedge clk_i);
    #1;
    tx_ack = 1'b1;
    clr(); s1 = '{8'h20, 8'h21}; eof1 = 1; s2 = '{8'h30, 8'h31}; eof2 = 1;
    rqst_ch1_data = 1'b1; rqst_ch2_data = 1'b1; cyc(); rqst_ch1_data = 1'b0; rqst_ch2_data = 1'b0;
    settle(60);
    expq = '{8'h01, 8'h20, 8'h21, 8'h02, 8'h30, 8'h31};
    ok("tie1 stream", q2s(txq) == q2s(expq));
    ok("tie1 frame_done", fd_cnt == 2);
    clr(); s1 = '{8'h22}; eof1 = 0; s2 = '{8'h32}; eof2 = 0;
    rqst_ch1_data = 1'b1; rqst_ch2_data = 1'b1; cyc(); rqst_ch1_data = 1'b0; rqst_ch2_data = 1'b0;
    settle(60);
    expq = '{8'h01, 8'h22, 8'h02, 8'h32};
    ok("tie2 stream", q2s(txq) == q2s(expq));
    clr(); s1 = '{8'h10, 8'h11, 8'h12}; eof1 = 2; s2 = '{8'h99}; eof2 = -1;
    rqst_ch1_data = 1'b1; cyc(); rqst_ch1_data = 1'b0;
    ok("single idle after rqst", busy === 1'b0);
    cyc();
    ok("single hdr busy", busy === 1'b1);
    ok("single hdr rdy", tx_rdy === 1'b1);
    ok("single hdr data", tx_data === 8'h01);
    settle(40);
    expq = '{8'h01, 8'h10, 8'h11, 8'h12};
    ok("single stream", q2s(txq) == q2s(expq));
    ok("single frame_done", fd_cnt == 1);
    ok("single truncated", tr_cnt == 0);
    ok("single ch2_ack", ack2_cnt == 0);
    ok("single ch2 consumed", i2 == 0);
    clr(); s1 = '{8'h23}; eof1 = 0; s2 = '{8'h33}; eof2 = 0;
    rqst_ch1_data = 1'b1; rqst_ch2_data = 1'b1; cyc(); rqst_ch1_data = 1'b0; rqst_ch2_data = 1'b0;
    settle(60);
    expq = '{8'h02, 8'h33, 8'h01, 8'h23};
    ok("tie3 stream", q2s(txq) == q2s(expq));
    clr(); s1.delete(); eof1 = -1; s2 = '{8'h40, 8'h41, 8'h42, 8'h43, 8'h44}; eof2 = 4;
    rnd2 = 1'b1; toggle = 1'b1; stab = 1'b1; hold_p = 1'b0; hold2 = 1'b0; tx_ack = 1'b0;
    rqst_ch2_data = 1'b1; cyc(); rqst_ch2_data = 1'b0;
    settle(100);
    rnd2 = 1'b0; toggle = 1'b0; stab = 1'b0; gate2 = 1'b1; tx_ack = 1'b1;
    expq = '{8'h02, 8'h40, 8'h41, 8'h42, 8'h43, 8'h44};
    ok("bp stream", q2s(txq) == q2s(expq));
    ok("bp frame_done", fd_cnt == 1);
    ok("bp eof at max not truncated", tr_cnt == 0);
    clr(); s1 = '{8'h50, 8'h51, 8'h52, 8'h53, 8'h54, 8'h55, 8'h56}; eof1 = -1; s2.delete();
    rqst_ch1_data = 1'b1; cyc(); rqst_ch1_data = 1'b0;
    settle(60);
    expq = '{8'h01, 8'h50, 8'h51, 8'h52, 8'h53, 8'h54};
    ok("trunc stream", q2s(txq) == q2s(expq));
    ok("trunc frame_done", fd_cnt == 1);
    ok("trunc truncated", tr_cnt == 1);
    ok("trunc alone", tr_only == 0);
    ok("trunc words acked", i1 == 5);
    clr(); s1 = '{8'h60, 8'h61, 8'h62, 8'h63, 8'h64}; eof1 = 4; s2 = '{8'h77}; eof2 = 0;
    rqst_ch1_data = 1'b1; cyc(); rqst_ch1_data = 1'b0;
    rqst_ch2_data = 1'b1; cyc(); rqst_ch2_data = 1'b0;
    for (int k = 0; k < 20 && i1 < 2; k++) cyc();
    ok("abort reached word 2", i1 == 2);
    abort = 1'b1; tx_ack = 1'b0; cyc(); abort = 1'b0; tx_ack = 1'b1;
    ok("abort tx_rdy", tx_rdy === 1'b0);
    ok("abort busy", busy === 1'b0);
    ok("abort frame_done", frame_done === 1'b1);
    busy_cnt = 0;
    repeat (10) cyc();
    ok("abort no ch2 frame", busy_cnt == 0);
    expq = '{8'h01, 8'h60, 8'h61};
    ok("abort stream", q2s(txq) == q2s(expq));
    ok("abort frame_done count", fd_cnt == 1);
    clr(); s1 = '{8'h70}; eof1 = 0; s2 = '{8'h78}; eof2 = 0; tx_ack = 1'b0;
    rqst_ch1_data = 1'b1; cyc(); rqst_ch1_data = 1'b0;
    cyc();
    ok("ares hdr rdy", tx_rdy === 1'b1);
    rqst_ch2_data = 1'b1; cyc(); rqst_ch2_data = 1'b0;
    #3 rst = 1'b0;
    #1;
    ok("ares tx_rdy", tx_rdy === 1'b0);
    ok("ares tx_data", tx_data === 8'h00);
    ok("ares busy", busy === 1'b0);
    @(negedge clk_i) rst = 1'b1;
    @(posedge clk_i);
    #1;
    tx_ack = 1'b1;
    busy_cnt = 0;
    repeat (8) cyc();
    ok("ares no frame", busy_cnt == 0);
    txq.delete();
    rqst_ch1_data = 1'b1; cyc(); rqst_ch1_data = 1'b0;
    settle(40);
    expq = '{8'h01, 8'h70};
    ok("ares new frame", q2s(txq) == q2s(expq));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
